// File: rtl/bcd_stopwatch_pkg.sv
// Shared constants for the BCD stopwatch: FSM state codes and BCD digit limits.
package bcd_stopwatch_pkg;

  // FSM state codes
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // BCD digit limits
  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  // A digit at or above nine is treated as nine, so a corrupted digit can never
  // count past the BCD range.
  function automatic logic bcd_is_nine(input logic [3:0] digit);
    return (digit >= BCD_NINE);
  endfunction

endpackage

// File: rtl/bcd_stopwatch_if.sv
// Control and status bundle of the BCD stopwatch.
// The master drives the control pulses. The slave, which is the stopwatch, returns the count and status.
interface bcd_stopwatch_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    Start;
  logic                    Stop;
  logic                    Clear;
  logic [4*NUM_DIGITS-1:0] Count;
  logic                    Running;
  logic                    Done;
  logic                    Overflow;

  modport master (
    output Start, Stop, Clear,
    input  Count, Running, Done, Overflow
  );

  modport slave (
    input  Start, Stop, Clear,
    output Count, Running, Done, Overflow
  );
endinterface

// File: rtl/bcd_stopwatch_digit.sv
// One BCD digit of the stopwatch counter.
// It counts 0..9 on carry-in and produces a carry-out when it rolls from 9 to 0.
// hold_i freezes the digit so that the counter can saturate at all-9s.
module bcd_digit
  import bcd_stopwatch_pkg::*;
(
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       clr_i,
  input  logic       inc_i,
  input  logic       hold_i,
  output logic [3:0] digit_o,
  output logic       is_nine_o,
  output logic       carry_o
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;
  logic       nine_s;

  assign nine_s    = bcd_is_nine(digit_q);
  assign is_nine_o = nine_s;
  assign carry_o   = inc_i & nine_s;
  assign digit_o   = digit_q;

  // Next digit value: clear wins, then a non-held increment with 9 -> 0 rollover
  always_comb begin
    digit_d = digit_q;
    if (clr_i) begin
      digit_d = BCD_ZERO;
    end else if (inc_i && !hold_i) begin
      digit_d = nine_s ? BCD_ZERO : (digit_q + 4'd1);
    end else begin
      digit_d = digit_q;
    end
  end

  // Digit register with asynchronous reset to zero
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      digit_q <= BCD_ZERO;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/bcd_stopwatch.sv
// N-digit BCD elapsed-time counter.
// It contains a tick prescaler, the IDLE/RUN/DONE control FSM, selectable
// saturate/wrap behaviour at all-9s and a sticky overflow flag.
module bcd_stopwatch #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 50000,
  parameter int WRAP_MODE  = 0
) (
  input  logic           Clock,
  input  logic           Resetn,
  bcd_stopwatch_if.slave sw
);
  import bcd_stopwatch_pkg::*;

  localparam int         PW      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRE_ONE = PW'(1);
  localparam logic [PW-1:0] PRE_ZERO = {PW{1'b0}};

  logic [1:0]              state_q;
  logic [1:0]              state_d;
  logic [PW-1:0]           pre_q;
  logic [PW-1:0]           pre_d;
  logic                    ovf_q;
  logic                    ovf_d;

  logic                    run_s;
  logic                    clr_s;
  logic                    tick_s;
  logic                    all_nine_s;
  logic                    sat_hold_s;
  logic                    ovf_evt_s;
  logic [NUM_DIGITS:0]     carry_s;
  logic [NUM_DIGITS-1:0]   nine_s;
  logic [4*NUM_DIGITS-1:0] digits_s;

  assign run_s  = (state_q == ST_RUN);
  assign clr_s  = sw.Clear | sw.Start;
  // A tick loses to Clear, Start and Stop. A Stop in the same cycle discards it.
  assign tick_s = run_s && (pre_q == PRE_MAX) && !sw.Clear && !sw.Start && !sw.Stop;

  assign all_nine_s = &nine_s;
  // In saturate mode every digit freezes once the whole count reads all-9s
  assign sat_hold_s = (WRAP_MODE == 0) && all_nine_s;
  assign carry_s[0] = tick_s;
  // A carry out of the top digit means the count has passed all-9s
  assign ovf_evt_s  = carry_s[NUM_DIGITS];

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    bcd_digit u_digit (
      .Clock     (Clock),
      .Resetn    (Resetn),
      .clr_i     (clr_s),
      .inc_i     (carry_s[k]),
      .hold_i    (sat_hold_s),
      .digit_o   (digits_s[4*k +: 4]),
      .is_nine_o (nine_s[k]),
      .carry_o   (carry_s[k+1])
    );
  end

  // FSM next state with priority Clear > Start > Stop > tick
  always_comb begin
    state_d = state_q;
    if (sw.Clear) begin
      state_d = ST_IDLE;
    end else if (sw.Start) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_RUN: begin
          if (sw.Stop) begin
            state_d = ST_DONE;
          end else if (ovf_evt_s && (WRAP_MODE == 0)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Prescaler next value. It advances only while running and restarts from 0 on each tick.
  always_comb begin
    pre_d = pre_q;
    if (clr_s) begin
      pre_d = PRE_ZERO;
    end else if (run_s && !sw.Stop) begin
      pre_d = (pre_q == PRE_MAX) ? PRE_ZERO : (pre_q + PRE_ONE);
    end else if (run_s) begin
      pre_d = PRE_ZERO;
    end else begin
      pre_d = pre_q;
    end
  end

  // Sticky overflow, cleared only by Clear or Start
  always_comb begin
    ovf_d = ovf_q;
    if (clr_s) begin
      ovf_d = 1'b0;
    end else if (ovf_evt_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State, prescaler and overflow registers with asynchronous reset
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      pre_q   <= PRE_ZERO;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sw.Count    = digits_s;
  assign sw.Running  = (state_q == ST_RUN);
  assign sw.Done     = (state_q == ST_DONE);
  assign sw.Overflow = ovf_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Self-checking bench for bcd_stopwatch.
// Two instances (saturate and wrap) share the same stimulus. Each is compared every cycle
// against an integer-arithmetic model of elapsed ticks.
module tb_bcd_stopwatch;
  localparam int ND = 2;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start_s = 1'b0;
  logic stop_s = 1'b0;
  logic clear_s = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  // model: count as an integer 0..99, phase in cycles, mode 0 idle / 1 run / 2 done
  int m_cnt [2];
  int m_ph  [2];
  int m_st  [2];
  int m_ov  [2];

  always #5 clk = ~clk;

  bcd_stopwatch_if #(.NUM_DIGITS(ND)) if0 ();
  bcd_stopwatch_if #(.NUM_DIGITS(ND)) if1 ();

  assign if0.Start = start_s;
  assign if0.Stop  = stop_s;
  assign if0.Clear = clear_s;
  assign if1.Start = start_s;
  assign if1.Stop  = stop_s;
  assign if1.Clear = clear_s;

  bcd_stopwatch #(.NUM_DIGITS(ND), .TICK_DIV(TD), .WRAP_MODE(0)) dut0 (
    .Clock(clk), .Resetn(rst_n), .sw(if0)
  );
  bcd_stopwatch #(.NUM_DIGITS(ND), .TICK_DIV(TD), .WRAP_MODE(1)) dut1 (
    .Clock(clk), .Resetn(rst_n), .sw(if1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_cnt[m] = 0; m_ph[m] = 0; m_st[m] = 0; m_ov[m] = 0;
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      if (clear_s) begin
        m_st[m] = 0; m_cnt[m] = 0; m_ph[m] = 0; m_ov[m] = 0;
      end else if (start_s) begin
        m_st[m] = 1; m_cnt[m] = 0; m_ph[m] = 0; m_ov[m] = 0;
      end else if (m_st[m] == 1 && stop_s) begin
        m_st[m] = 2; m_ph[m] = 0;
      end else if (m_st[m] == 1) begin
        if (m_ph[m] == TD - 1) begin
          m_ph[m] = 0;
          if (m_cnt[m] == 99) begin
            m_ov[m] = 1;
            if (m == 1) m_cnt[m] = 0;
            else m_st[m] = 2;
          end else begin
            m_cnt[m] = m_cnt[m] + 1;
          end
        end else begin
          m_ph[m] = m_ph[m] + 1;
        end
      end
    end
  endtask

  function automatic logic [31:0] exp_vec(input int m);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'(m_cnt[m] / 10);
    lo = 4'(m_cnt[m] % 10);
    return {21'd0, hi, lo, (m_st[m] == 1), (m_st[m] == 2), (m_ov[m] != 0)};
  endfunction

  function automatic logic [31:0] obs0();
    return {21'd0, if0.Count, if0.Running, if0.Done, if0.Overflow};
  endfunction

  function automatic logic [31:0] obs1();
    return {21'd0, if1.Count, if1.Running, if1.Done, if1.Overflow};
  endfunction

  // one clock: model advances on the edge, outputs are compared on the falling edge
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("sat_model", obs0(), exp_vec(0));
    check("wrap_model", obs1(), exp_vec(1));
    start_s = 1'b0;
    stop_s  = 1'b0;
    clear_s = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse_start();
    start_s = 1'b1;
    cycle();
  endtask

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    check("reset_sat", obs0(), 32'd0);
    check("reset_wrap", obs1(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // first count and tens carry
    pulse_start();
    check("start_running", 32'(if0.Running), 32'd1);
    run(3);
    check("cnt_before_first", 32'(if0.Count), 32'h00);
    run(1);
    check("cnt_first_tick", 32'(if0.Count), 32'h01);
    run(36);
    check("cnt_40_edges", 32'(if0.Count), 32'h10);

    // asynchronous reset mid-run, observed before any further edge
    run(7);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_sat", obs0(), 32'd0);
    check("async_rst_wrap", obs1(), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run(2);

    // stop 23 edges after start, then freeze
    pulse_start();
    run(22);
    stop_s = 1'b1;
    cycle();
    check("stop_cnt", 32'(if0.Count), 32'h05);
    check("stop_done", 32'(if0.Done), 32'd1);
    run(100);
    check("frozen_cnt", 32'(if0.Count), 32'h05);
    stop_s = 1'b1;
    cycle();
    check("second_stop", 32'(if0.Count), 32'h05);

    // stop in the same cycle as a tick discards that tick
    pulse_start();
    run(23);
    stop_s = 1'b1;
    cycle();
    check("stop_on_tick", 32'(if1.Count), 32'h05);
    check("stop_on_tick_done", 32'(if1.Done), 32'd1);

    // all-9s plus one tick: saturate vs wrap
    pulse_start();
    run(396);
    check("at_99", 32'(if0.Count), 32'h99);
    run(4);
    check("sat_final", obs0(), {21'd0, 8'h99, 1'b0, 1'b1, 1'b1});
    check("wrap_final", obs1(), {21'd0, 8'h00, 1'b1, 1'b0, 1'b1});
    run(4);
    check("wrap_next", obs1(), {21'd0, 8'h01, 1'b1, 1'b0, 1'b1});

    // Clear together with Start wins, then Start from DONE restarts from zero
    pulse_start();
    run(148);
    check("at_37", 32'(if1.Count), 32'h37);
    clear_s = 1'b1;
    start_s = 1'b1;
    cycle();
    check("clear_wins", obs1(), 32'd0);
    pulse_start();
    run(5);
    stop_s = 1'b1;
    cycle();
    check("done_before_restart", 32'(if0.Done), 32'd1);
    pulse_start();
    run(3);
    check("restart_zero", 32'(if0.Count), 32'h00);
    run(1);
    check("restart_first", 32'(if0.Count), 32'h01);

    // randomized control pulses
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 999));
      start_s = (r < 5);
      stop_s  = (r >= 5 && r < 25);
      clear_s = (r >= 25 && r < 28);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bcd_stopwatch.md
Name: bcd_stopwatch

Overview:
Parametrised N-digit BCD elapsed-time counter with an internal tick prescaler and a start/stop/clear control FSM. It is the successor of the fixed 4-digit free-running BCD counter and is the timing core of the reaction timer. It adds configurable digit count and tick rate, explicit stop/freeze, a selectable saturate/wrap mode and a sticky overflow flag. Everything is fully synchronous to Clock; no logic is clocked off a data signal.

Parameters:
NUM_DIGITS, 4, number of BCD digits (1..8); digit 0 is least significant.
TICK_DIV, 50000, Clock cycles per count increment (>=2); 50000 gives 1 ms at 50 MHz.
WRAP_MODE, 0, 0 = saturate at all-9s and stop; 1 = roll over to all-0s and keep running.

Ports:
Clock  input  1  system clock, all state updates on rising edge
Resetn  input  1  asynchronous active-low reset
Start  input  1  single-cycle pulse: zero the count and begin counting
Stop  input  1  single-cycle pulse: freeze the count
Clear  input  1  synchronous clear to IDLE, highest priority
Count  output  4*NUM_DIGITS  packed BCD value, digit k at bits [4k+3:4k]
Running  output  1  high while state = RUN
Done  output  1  high while state = DONE (count frozen, valid for display)
Overflow  output  1  sticky: count has passed all-9s since last Start/Clear

Behaviour:
- Reset (Resetn low, asynchronous): state = IDLE, Count = 0, prescaler = 0, Running = 0, Done = 0, Overflow = 0.
- States: IDLE, RUN, DONE. Running and Done are decoded directly from the state register.
- Per-cycle priority: Clear > Start > Stop > tick.
- Clear (any state): next state IDLE, Count = 0, prescaler = 0, Overflow = 0.
- Start (any state, Clear low): next state RUN, Count = 0, prescaler = 0, Overflow = 0. Start while in RUN is a restart.
- Stop in RUN (Clear and Start low): next state DONE and Count holds. A tick in the same cycle is discarded. Stop in IDLE or DONE is ignored.
- Prescaler: counts 0..TICK_DIV-1 only in RUN. tick = (prescaler == TICK_DIV-1) in RUN, after which the prescaler returns to 0.
- Latency: Start sampled at edge E sets Running at E. Count becomes 1 at the TICK_DIV-th edge after E, and then increments every TICK_DIV edges.
- Increment on tick: digit 0 += 1. A digit at 9 with carry-in goes to 0 and carries out; carries ripple in the same cycle. Digits never exceed 9.
- All-9s plus tick, WRAP_MODE = 0: Count stays all-9s, Overflow = 1, next state DONE.
- All-9s plus tick, WRAP_MODE = 1: Count = 0, Overflow = 1, state stays RUN.
- Overflow is cleared only by Reset, Clear or Start.
- Resetn asserted mid-count: immediate return to reset values with no waiting for a clock edge. Resetn is released synchronously by the top level.
- Start and Stop are single-cycle pulses, debounced and synchronised upstream. If held high, Start re-zeroes the count on every cycle.

Decomposition:
- Package bcd_stopwatch_pkg: state enum encoding (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2), BCD_NINE = 4'd9, BCD_ZERO = 4'd0.
- Sub-module bcd_digit: one 4-bit BCD digit register with Clock, Resetn, clr, inc (carry-in) and is_nine/carry-out, plus a saturate-hold input. Instantiated NUM_DIGITS times in a generate loop, with carry-out chained to the next digit's inc.
- The top module holds the FSM, the prescaler ($clog2(TICK_DIV) bits) and the overflow flag.

Test Plan:
1. NUM_DIGITS=2, TICK_DIV=4: Resetn low mid-run -> all outputs 0 within the same cycle, without waiting for a Clock edge. Release, Start pulse -> Running=1; Count=8'h01 after 4 edges; Count=8'h10 after 40 edges.
2. Stop pulse at 23 edges after Start -> Done=1, Count=8'h05. Count stays 8'h05 for 100 further edges. A second Stop has no effect.
3. Stop asserted in the same cycle as the tick that would make 8'h05 into 8'h06 -> Count stays 8'h05, Done=1.
4. WRAP_MODE=0, run to 8'h99 and then one more tick -> Count=8'h99, Overflow=1, Done=1, Running=0.
5. WRAP_MODE=1, same stimulus -> Count=8'h00, Overflow=1, Running=1. The next tick gives Count=8'h01 and Overflow remains 1.
6. In RUN at Count=8'h37, assert Clear and Start together -> IDLE, Count=0, Overflow=0. Start alone in DONE -> RUN from 8'h00 with the prescaler at 0.
